// File: rtl/cp0_regs_if.sv
// CP0 bus between the decode stage (master) and the coprocessor-0 block (slave).
// The read/write bus packs {wdata[31:0], reg[4:0], mtc0_strobe}.
`ifndef CP0_RW_BUS_WIDTH
`define CP0_RW_BUS_WIDTH         38
`define BUS_DECODE_CP0_REG_DATA  37:6
`define BUS_DECODE_CP0_REG       5:1
`define BUS_DECODE_CP0_REG_W     0
`endif

interface cp0_regs_if;
   logic                          pipeline_ready;
   logic [`CP0_RW_BUS_WIDTH-1:0]  cp0_rw_bus;
   logic [31:0]                   cp0_reg_out;
   logic                          s_syscall;
   logic                          s_eret;
   logic [31:0]                   exc_pc;
   logic [5:0]                    hw_int;
   logic                          exc_redirect;
   logic [31:0]                   exc_target;
   logic [31:0]                   epc;
   logic                          int_pending;

   modport master (
      output pipeline_ready, cp0_rw_bus, s_syscall, s_eret, exc_pc, hw_int,
      input  cp0_reg_out, exc_redirect, exc_target, epc, int_pending
   );

   modport slave (
      input  pipeline_ready, cp0_rw_bus, s_syscall, s_eret, exc_pc, hw_int,
      output cp0_reg_out, exc_redirect, exc_target, epc, int_pending
   );
endinterface

// File: rtl/cp0_regs.sv
// CP0 register file and exception sequencer for the 5-stage MIPS core.
// Holds Count/Compare/Status/Cause/EPC and issues a one-cycle fetch redirect.
module cp0_regs #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
   parameter bit          COUNT_HALF = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   cp0_regs_if.slave cp0
);

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_SYS     = 5'd8;

   logic [31:0] r_count;
   logic        r_count_tog;
   logic [31:0] r_compare;
   logic        r_timer;
   logic [7:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic [1:0]  r_ip_sw;
   logic [4:0]  r_exc_code;
   logic [31:0] r_epc;
   logic        r_exc_redirect;
   logic [31:0] r_exc_target;

   logic [31:0] w_wdata;
   logic [4:0]  w_reg;
   logic        w_we;
   logic [7:0]  w_ip;
   logic        w_int_pending;
   logic        w_take_int;
   logic        w_take_sys;
   logic        w_take_eret;
   logic        w_event;
   logic        w_mtc0;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_wr_status;
   logic        w_wr_cause;
   logic        w_wr_epc;
   logic        w_count_inc;
   logic [31:0] w_count_plus1;
   logic        w_timer_hit;
   logic [31:0] w_status;
   logic [31:0] w_cause;
   logic [31:0] w_read;

   assign w_wdata = cp0.cp0_rw_bus[`BUS_DECODE_CP0_REG_DATA];
   assign w_reg   = cp0.cp0_rw_bus[`BUS_DECODE_CP0_REG];
   assign w_we    = cp0.cp0_rw_bus[`BUS_DECODE_CP0_REG_W];

   // Hardware lines and the timer are live levels; only IP[9:8] is stored.
   assign w_ip          = {cp0.hw_int[5] | r_timer, cp0.hw_int[4:0], r_ip_sw};
   assign w_int_pending = r_ie & ~r_exl & (|(w_ip & r_im));

   assign w_take_int  = cp0.pipeline_ready & w_int_pending;
   assign w_take_sys  = cp0.pipeline_ready & cp0.s_syscall & ~w_int_pending;
   assign w_take_eret = cp0.pipeline_ready & cp0.s_eret & ~w_int_pending & ~cp0.s_syscall;
   assign w_event     = w_take_int | w_take_sys | w_take_eret;

   assign w_mtc0       = cp0.pipeline_ready & w_we & ~w_event;
   assign w_wr_count   = w_mtc0 && (w_reg == REG_COUNT);
   assign w_wr_compare = w_mtc0 && (w_reg == REG_COMPARE);
   assign w_wr_status  = w_mtc0 && (w_reg == REG_STATUS);
   assign w_wr_cause   = w_mtc0 && (w_reg == REG_CAUSE);
   assign w_wr_epc     = w_mtc0 && (w_reg == REG_EPC);

   assign w_count_inc   = COUNT_HALF ? r_count_tog : 1'b1;
   assign w_count_plus1 = r_count + 32'd1;
   assign w_timer_hit   = w_count_inc & ~w_wr_count & (w_count_plus1 == r_compare);

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count     <= '0;
         r_count_tog <= 1'b0;
      end else if (w_wr_count) begin
         r_count     <= w_wdata;
         r_count_tog <= 1'b0;
      end else begin
         r_count_tog <= ~r_count_tog;
         if (w_count_inc) r_count <= w_count_plus1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_compare <= '0;
         r_timer   <= 1'b0;
      end else if (w_wr_compare) begin
         r_compare <= w_wdata;
         r_timer   <= 1'b0;
      end else if (w_timer_hit) begin
         r_timer   <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_im  <= '0;
         r_exl <= 1'b0;
         r_ie  <= 1'b0;
      end else begin
         if (w_wr_status) begin
            r_im  <= w_wdata[15:8];
            r_exl <= w_wdata[1];
            r_ie  <= w_wdata[0];
         end
         if (w_take_int || w_take_sys) r_exl <= 1'b1;
         else if (w_take_eret)         r_exl <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ip_sw    <= '0;
         r_exc_code <= '0;
         r_epc      <= '0;
      end else begin
         if (w_wr_cause) r_ip_sw <= w_wdata[9:8];
         if (w_wr_epc)   r_epc   <= w_wdata;
         if (w_take_int) begin
            r_epc      <= cp0.exc_pc;
            r_exc_code <= EXC_INT;
         end else if (w_take_sys) begin
            r_epc      <= cp0.exc_pc;
            r_exc_code <= EXC_SYS;
         end
      end
   end

   // Eret returns to the EPC held when it was accepted, not the one being written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exc_redirect <= 1'b0;
         r_exc_target   <= '0;
      end else begin
         r_exc_redirect <= w_event;
         if (w_event) r_exc_target <= w_take_eret ? r_epc : EXC_VECTOR;
      end
   end

   assign w_status = {16'b0, r_im, 6'b0, r_exl, r_ie};
   assign w_cause  = {1'b0, r_timer, 14'b0, w_ip, 1'b0, r_exc_code, 2'b0};

   // NOTE: a default ahead of the case keeps the read mux free of inferred latches.
   always_comb begin
      w_read = '0;
      case (w_reg)
         REG_COUNT:   w_read = r_count;
         REG_COMPARE: w_read = r_compare;
         REG_STATUS:  w_read = w_status;
         REG_CAUSE:   w_read = w_cause;
         REG_EPC:     w_read = r_epc;
         default:     w_read = '0;
      endcase
   end

   assign cp0.cp0_reg_out  = w_read;
   assign cp0.exc_redirect = r_exc_redirect;
   assign cp0.exc_target   = r_exc_target;
   assign cp0.epc          = r_epc;
   assign cp0.int_pending  = w_int_pending;

endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: a half-rate and a full-rate Count instance share one stimulus
// stream and are compared every cycle against a register-level behavioural model.
module tb_cp0_regs;

   localparam logic [31:0] VEC = 32'h0000_0380;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Shared stimulus
   logic        ready = 1'b1;
   logic        we    = 1'b0;
   logic [4:0]  rsel  = 5'd9;
   logic [31:0] wdata = '0;
   logic        sys   = 1'b0;
   logic        eret  = 1'b0;
   logic [31:0] pc    = '0;
   logic [5:0]  hw    = '0;

   cp0_regs_if bus_h ();
   cp0_regs_if bus_f ();

   assign bus_h.pipeline_ready = ready;
   assign bus_h.cp0_rw_bus     = {wdata, rsel, we};
   assign bus_h.s_syscall      = sys;
   assign bus_h.s_eret         = eret;
   assign bus_h.exc_pc         = pc;
   assign bus_h.hw_int         = hw;
   assign bus_f.pipeline_ready = ready;
   assign bus_f.cp0_rw_bus     = {wdata, rsel, we};
   assign bus_f.s_syscall      = sys;
   assign bus_f.s_eret         = eret;
   assign bus_f.exc_pc         = pc;
   assign bus_f.hw_int         = hw;

   cp0_regs #(.EXC_VECTOR(VEC), .COUNT_HALF(1'b1)) dut_half (.clk(clk), .rst(rst), .cp0(bus_h.slave));
   cp0_regs #(.EXC_VECTOR(VEC), .COUNT_HALF(1'b0)) dut_full (.clk(clk), .rst(rst), .cp0(bus_f.slave));

   logic [31:0] o_rd[2], o_tgt[2], o_epc[2];
   logic        o_red[2], o_ip[2];
   assign o_rd[0]  = bus_h.cp0_reg_out;  assign o_rd[1]  = bus_f.cp0_reg_out;
   assign o_tgt[0] = bus_h.exc_target;   assign o_tgt[1] = bus_f.exc_target;
   assign o_epc[0] = bus_h.epc;          assign o_epc[1] = bus_f.epc;
   assign o_red[0] = bus_h.exc_redirect; assign o_red[1] = bus_f.exc_redirect;
   assign o_ip[0]  = bus_h.int_pending;  assign o_ip[1]  = bus_f.int_pending;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model, index 0 = half-rate Count, 1 = full-rate Count.
   // Count is held as (value at last load) + elapsed cycles scaled by the rate.
   logic [31:0] m_base[2], m_compare[2], m_epc[2], m_target[2];
   int unsigned m_cyc[2];
   logic [7:0]  m_im[2];
   logic        m_exl[2], m_ie[2], m_timer[2], m_red[2];
   logic [1:0]  m_swip[2];
   logic [4:0]  m_exc[2];

   function automatic logic [31:0] m_count(input int k);
      return m_base[k] + ((k == 0) ? (m_cyc[k] / 2) : m_cyc[k]);
   endfunction

   function automatic logic [7:0] m_ip(input int k);
      return {hw[5] | m_timer[k], hw[4:0], m_swip[k]};
   endfunction

   function automatic logic m_intp(input int k);
      return m_ie[k] && !m_exl[k] && ((m_ip(k) & m_im[k]) != 8'h00);
   endfunction

   function automatic logic [31:0] m_read(input int k, input logic [4:0] r);
      case (r)
         5'd9:    return m_count(k);
         5'd11:   return m_compare[k];
         5'd12:   return (32'(m_im[k]) << 8) | (32'(m_exl[k]) << 1) | 32'(m_ie[k]);
         5'd13:   return (32'(m_timer[k]) << 30) | (32'(m_ip(k)) << 8) | (32'(m_exc[k]) << 2);
         5'd14:   return m_epc[k];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_base[k] = '0; m_cyc[k] = 0; m_compare[k] = '0; m_epc[k] = '0;
         m_target[k] = '0; m_im[k] = '0; m_exl[k] = 1'b0; m_ie[k] = 1'b0;
         m_timer[k] = 1'b0; m_red[k] = 1'b0; m_swip[k] = '0; m_exc[k] = '0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         logic        intp, t_int, t_sys, t_eret, evt, wr;
         logic [31:0] c_old, c_new;
         intp   = m_intp(k);
         t_int  = ready && intp;
         t_sys  = ready && sys && !intp;
         t_eret = ready && eret && !intp && !sys;
         evt    = t_int || t_sys || t_eret;
         wr     = ready && we && !evt;
         c_old  = m_count(k);
         if (wr && rsel == 5'd9) begin
            m_base[k] = wdata;
            m_cyc[k]  = 0;
         end else begin
            m_cyc[k]++;
         end
         c_new = m_count(k);
         if (wr && rsel == 5'd11) begin
            m_compare[k] = wdata;
            m_timer[k]   = 1'b0;
         end else if (!(wr && rsel == 5'd9) && c_new != c_old && c_new == m_compare[k]) begin
            m_timer[k] = 1'b1;
         end
         m_red[k] = evt;
         if (evt) m_target[k] = t_eret ? m_epc[k] : VEC;
         if (wr && rsel == 5'd12) begin
            m_im[k] = wdata[15:8]; m_exl[k] = wdata[1]; m_ie[k] = wdata[0];
         end
         if (wr && rsel == 5'd13) m_swip[k] = wdata[9:8];
         if (wr && rsel == 5'd14) m_epc[k] = wdata;
         if (t_int || t_sys) begin
            m_epc[k] = pc;
            m_exc[k] = t_int ? 5'd0 : 5'd8;
            m_exl[k] = 1'b1;
         end else if (t_eret) begin
            m_exl[k] = 1'b0;
         end
      end
   endtask

   // Per-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         check($sformatf("redirect[%0d]", k), 32'(o_red[k]), 32'(m_red[k]));
         if (m_red[k]) check($sformatf("target[%0d]", k), o_tgt[k], m_target[k]);
         check($sformatf("epc[%0d]", k), o_epc[k], m_epc[k]);
         check($sformatf("int_pending[%0d]", k), 32'(o_ip[k]), 32'(m_intp(k)));
         check($sformatf("reg%0d[%0d]", rsel, k), o_rd[k], m_read(k, rsel));
      end
   end

   task automatic step();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic drive(input logic rdy, input logic w, input logic [4:0] r,
                        input logic [31:0] d, input logic s, input logic e);
      ready = rdy; we = w; rsel = r; wdata = d; sys = s; eret = e;
      step();
      we = 1'b0; sys = 1'b0; eret = 1'b0;
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, 5'd9, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic expect_reg(input int k, input logic [4:0] r, input logic [31:0] exp, input string name);
      rsel = r;
      #1;
      check(name, o_rd[k], exp);
   endtask

   initial begin
      model_reset();
      step();
      step();
      check("rst_redirect", 32'(o_red[0]), 32'h0);
      check("rst_target", o_tgt[0], 32'h0);
      check("rst_epc", o_epc[1], 32'h0);
      expect_reg(0, 5'd9, 32'h0, "rst_count");
      rst = 1'b0;

      repeat (10) idle();
      expect_reg(0, 5'd9, 32'd5, "count_half_10cyc");
      expect_reg(1, 5'd9, 32'd10, "count_full_10cyc");

      // Timer interrupt
      drive(1'b1, 1'b1, 5'd11, 32'd8, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 5'd12, 32'h0000_8001, 1'b0, 1'b0);
      pc = 32'h0040_0010;
      for (int i = 0; i < 20 && !o_ip[0]; i++) idle();
      check("timer_int_pending", 32'(o_ip[0]), 32'h1);
      expect_reg(0, 5'd13, 32'h4000_8000, "cause_ti_set");
      idle();
      check("int_epc", o_epc[0], 32'h0040_0010);
      check("int_redirect", 32'(o_red[0]), 32'h1);
      check("int_target", o_tgt[0], 32'h0000_0380);
      expect_reg(0, 5'd12, 32'h0000_8003, "int_status_exl");
      drive(1'b1, 1'b1, 5'd11, 32'd8, 1'b0, 1'b0);
      expect_reg(0, 5'd13, 32'h0000_0000, "cause_ti_clear");

      // Only the software IP bits of Cause are writable
      drive(1'b1, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0);
      expect_reg(0, 5'd13, 32'h0000_0300, "cause_write_half");
      expect_reg(1, 5'd13, 32'h0000_0300, "cause_write_full");
      drive(1'b1, 1'b1, 5'd13, 32'h0, 1'b0, 1'b0);

      // Syscall then eret
      drive(1'b1, 1'b1, 5'd12, 32'h0, 1'b0, 1'b0);
      pc = 32'h0040_0020;
      drive(1'b1, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0);
      check("sys_epc", o_epc[0], 32'h0040_0020);
      check("sys_redirect", 32'(o_red[0]), 32'h1);
      check("sys_target", o_tgt[0], 32'h0000_0380);
      expect_reg(0, 5'd13, 32'h0000_0020, "sys_exccode");
      drive(1'b1, 1'b0, 5'd9, 32'h0, 1'b0, 1'b1);
      check("eret_redirect", 32'(o_red[0]), 32'h1);
      check("eret_target", o_tgt[0], 32'h0040_0020);
      expect_reg(0, 5'd12, 32'h0, "eret_status");

      // Event suppresses same-cycle mtc0
      pc = 32'h0040_0030;
      drive(1'b1, 1'b1, 5'd12, 32'hFFFF_FFFF, 1'b1, 1'b0);
      expect_reg(0, 5'd12, 32'h0000_0002, "sys_drops_mtc0");

      // pipeline_ready low blocks everything
      pc = 32'h0040_0040;
      drive(1'b0, 1'b1, 5'd14, 32'h1234_5678, 1'b1, 1'b0);
      check("stall_epc", o_epc[0], 32'h0040_0030);
      check("stall_redirect", 32'(o_red[0]), 32'h0);
      drive(1'b1, 1'b1, 5'd14, 32'h1234_5678, 1'b1, 1'b0);
      check("ready_epc", o_epc[0], 32'h0040_0040);
      check("ready_redirect", 32'(o_red[0]), 32'h1);

      // Count wrap
      drive(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 1'b0, 1'b0);
      expect_reg(1, 5'd9, 32'hFFFF_FFFF, "count_load");
      idle();
      expect_reg(1, 5'd9, 32'h0, "count_wrap_full");
      expect_reg(0, 5'd9, 32'hFFFF_FFFF, "count_hold_half");
      idle();
      expect_reg(0, 5'd9, 32'h0, "count_wrap_half");

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         logic [4:0]  r;
         logic [31:0] d;
         case ($urandom % 6)
            0:       r = 5'd9;
            1:       r = 5'd11;
            2:       r = 5'd12;
            3:       r = 5'd13;
            4:       r = 5'd14;
            default: r = 5'($urandom_range(0, 31));
         endcase
         d  = ((r == 5'd9 || r == 5'd11) && ($urandom % 2 == 0)) ? $urandom_range(0, 24) : $urandom;
         pc = $urandom & 32'hFFFF_FFFC;
         hw = ($urandom % 8 == 0) ? 6'($urandom) : 6'h0;
         drive(($urandom % 4) != 0, ($urandom % 3) == 0, r, d,
               ($urandom % 16) == 0, ($urandom % 16) == 0);
      end
      hw = '0;

      // Async reset during a redirect
      pc = 32'h0040_0050;
      drive(1'b1, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0);
      check("pre_rst_redirect", 32'(o_red[0]), 32'h1);
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_drops_redirect", 32'(o_red[0]), 32'h0);
      check("rst_drops_redirect_full", 32'(o_red[1]), 32'h0);
      check("rst_clears_target", o_tgt[0], 32'h0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 register file and exception sequencer for the 5-stage MIPS core.
- Responds to the CP0 read/write bus and the syscall/eret strobes driven by the decode stage, and returns the mfc0 read data.
- Maintains Count/Compare/Status/Cause/EPC, detects interrupts, and issues a one-cycle PC redirect so the fetch stage can flush.

Parameters:
- EXC_VECTOR, 32'h0000_0380, redirect target for syscall and interrupt.
- COUNT_HALF, 1, 1: Count increments every 2nd cycle; 0: every cycle.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pipeline_ready  in  1  decode stage advancing; all writes and events are accepted only when 1
- cp0_rw_bus  in  `CP0_RW_BUS_WIDTH  fields `BUS_DECODE_CP0_REG_DATA (wdata 32), `BUS_DECODE_CP0_REG (reg 5), `BUS_DECODE_CP0_REG_W (mtc0 strobe)
- cp0_reg_out  out  32  combinational read of the register selected by the bus reg field
- s_syscall  in  1  syscall in decode
- s_eret  in  1  eret in decode
- exc_pc  in  32  PC of the instruction in decode (EPC source)
- hw_int  in  6  level hardware interrupts, mapped to Cause.IP[7:2]
- exc_redirect  out  1  registered one-cycle redirect/flush pulse
- exc_target  out  32  redirect PC, valid while exc_redirect=1
- epc  out  32  current EPC
- int_pending  out  1  interrupt would be taken this cycle

Behaviour:
- Register map (reg field): 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Others read 0 and ignore writes.
- Status: IM[15:8], EXL[1], IE[0] implemented. Other bits read 0 and are not writable.
- Cause: TI[30], IP[15:8], ExcCode[6:2]. Only IP[9:8] (software) is writable by mtc0. IP[14:10] = hw_int[4:0] and IP[15] = hw_int[5] | timer, sampled each cycle.
- Reset (async): all registers 0, count toggle 0, exc_redirect 0, exc_target 0, timer flag 0.
- Read: cp0_reg_out is pure combinational on current register state. An mtc0 to the same register in the same cycle is not bypassed (old value returned).
- Count:
  - COUNT_HALF=1: a toggle flips every cycle; Count += 1 on cycles where the toggle is 1. COUNT_HALF=0: increments every cycle.
  - Wraps 32'hFFFF_FFFF -> 0.
  - mtc0 Count loads wdata and clears the toggle; the load overrides the increment that cycle.
- Timer:
  - Flag sets on the edge where an increment makes Count equal Compare. It does not set for equal values at reset.
  - Flag is sticky and reflected in TI and IP[7].
  - mtc0 Compare clears the flag and loads Compare. If a set and a clear coincide, the clear wins.
- int_pending = IE & ~EXL & |(Cause.IP[15:8] & Status.IM).
- Events are evaluated only when pipeline_ready=1. Priority: interrupt > syscall > eret.
  - Interrupt: EPC<=exc_pc, ExcCode<=0, EXL<=1. Next cycle: exc_redirect=1, exc_target=EXC_VECTOR. If a syscall is present it is dropped; it re-executes after eret.
  - Syscall: EPC<=exc_pc, ExcCode<=8, EXL<=1. Next cycle: redirect to EXC_VECTOR.
  - Eret: EXL<=0. Next cycle: redirect to the EPC value held at acceptance.
- Any accepted event suppresses the mtc0 in the same cycle entirely.
- exc_redirect lasts exactly one cycle and is cleared the following cycle even if pipeline_ready=0.
- pipeline_ready=0: no mtc0, no events. Count/timer/hw_int sampling continue.
- Syscall or interrupt while EXL=1: interrupts are masked. Syscall is still taken and overwrites EPC (no nesting support).
- Reset mid-redirect: exc_redirect drops immediately (async).

Test Plan:
- Reset, COUNT_HALF=1, run 10 cycles -> Count=5, cp0_reg_out=5 with reg=9; exc_redirect stays 0.
- mtc0 Compare=8, Status=32'h0000_8001 -> timer flag sets when Count reaches 8; int_pending=1. With exc_pc=32'h0040_0010, next edge EPC=32'h0040_0010, Cause.ExcCode=0, EXL=1; following cycle exc_redirect=1, exc_target=32'h380. mtc0 Compare=8 again -> TI=0.
- s_syscall with exc_pc=32'h0040_0020, IE=0 -> EPC=32'h0040_0020, Cause[6:2]=8, redirect to 32'h380. Then s_eret -> EXL=0, redirect with exc_target=32'h0040_0020.
- s_syscall together with mtc0 Status=32'hFFFF_FFFF -> Status only EXL set; mtc0 dropped.
- pipeline_ready=0 with s_syscall=1 and mtc0 EPC -> no register change, no redirect. Raising pipeline_ready -> event taken.
- mtc0 Count=32'hFFFF_FFFF, COUNT_HALF=0 -> next cycle Count=0. Write Cause=32'hFFFF_FFFF with hw_int=0, timer flag clear -> Cause reads 32'h0000_0300.
